cmd_replay_fifo: RTL and testbench

CMD_REPLAY_FIFO -- requirements
Module: cmd_replay_fifo

---
 rtl/cmd_replay_fifo_pkg.sv | 22 ++
 rtl/cmd_replay_fifo_if.sv | 34 +++
 rtl/replay_fifo_mem.sv | 27 ++
 rtl/cmd_replay_fifo.sv | 153 +++++++++++++++
 tb/tb_cmd_replay_fifo.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_replay_fifo_pkg.sv
// Shared constants and types for the command replay FIFO.
// Fallback definitions apply only when the shared sys_defs header has not been compiled first.
`ifndef Packet_size
`define Packet_size 32
`endif
`ifndef Max_replay_Iter
`define Max_replay_Iter 8
`endif

package cmd_replay_fifo_pkg;

  localparam int PACKET_SIZE     = `Packet_size;
  localparam int MAX_REPLAY_ITER = `Max_replay_Iter;
  localparam int ITER_W_DEFAULT  = $clog2(MAX_REPLAY_ITER);

  // S_IDLE: no segment open; S_PASS: a segment is being read and may be rewound.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_PASS = 1'b1
  } state_e;

endpackage

// File: rtl/cmd_replay_fifo_if.sv
// Write/read handshake bundle of the command replay FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface cmd_replay_fifo_if #(
  parameter int DATA_W = cmd_replay_fifo_pkg::PACKET_SIZE,
  parameter int DEPTH  = 16,
  parameter int ITER_W = cmd_replay_fifo_pkg::ITER_W_DEFAULT
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              winc;
  logic [DATA_W-1:0] wdata;
  logic              wlast;
  logic              wfull;
  logic [CW-1:0]     count;
  logic              rinc;
  logic [ITER_W-1:0] replay_num;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic [ITER_W-1:0] pass_idx;
  logic              seg_overflow;

  modport master (
    output winc, wdata, wlast, rinc, replay_num,
    input  wfull, count, rvalid, rdata, rlast, pass_idx, seg_overflow
  );

  modport slave (
    input  winc, wdata, wlast, rinc, replay_num,
    output wfull, count, rvalid, rdata, rlast, pass_idx, seg_overflow
  );

endinterface

// File: rtl/replay_fifo_mem.sv
// Entry storage for the replay FIFO: one synchronous write port, one asynchronous read port.
// Each word holds {wlast, packet}.
module replay_fifo_mem #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; the pointer logic never exposes an unwritten word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cmd_replay_fifo.sv
// Command FIFO whose segments (runs ending in wlast) can be re-read replay_num extra times
// before their entries are released; free_ptr trails rd_ptr until a segment's final pass.
module cmd_replay_fifo
  import cmd_replay_fifo_pkg::*;
#(
  parameter int DATA_W = PACKET_SIZE,
  parameter int DEPTH  = 16,
  parameter int ITER_W = ITER_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  cmd_replay_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]     PTR_FULL = PW'(DEPTH);
  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

  state_e            state_q,        state_d;
  logic [PW-1:0]     wr_ptr_q,       wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q,       rd_ptr_d;
  logic [PW-1:0]     free_ptr_q,     free_ptr_d;
  logic [PW-1:0]     seg_start_q,    seg_start_d;
  logic [PW-1:0]     pending_last_q, pending_last_d;
  logic [ITER_W-1:0] iter_target_q,  iter_target_d;
  logic [ITER_W-1:0] pass_idx_q,     pass_idx_d;
  logic              seg_overflow_q, seg_overflow_d;

  logic [DATA_W:0]   rd_word;
  logic [PW-1:0]     count;
  logic              wfull;
  logic              rvalid;
  logic              rlast;
  logic              wr_acc;
  logic              rd_acc;
  logic              last_inc;
  logic              last_dec;
  logic [PW-1:0]     eff_start;
  logic [ITER_W-1:0] eff_target;
  logic [ITER_W-1:0] eff_pass;

  assign count  = wr_ptr_q - free_ptr_q;
  assign wfull  = (count == PTR_FULL);
  assign rvalid = (rd_ptr_q != wr_ptr_q);
  assign rlast  = rd_word[DATA_W];
  assign wr_acc = bus.winc & ~wfull;
  assign rd_acc = bus.rinc & rvalid;

  replay_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & ~reset & ~flush),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({bus.wlast, bus.wdata}),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_word)
  );

  // The first read of a segment latches its start and replay count in the same cycle it is consumed.
  always_comb begin
    eff_start  = (state_q == S_IDLE) ? rd_ptr_q   : seg_start_q;
    eff_target = (state_q == S_IDLE) ? bus.replay_num : iter_target_q;
    eff_pass   = (state_q == S_IDLE) ? '0         : pass_idx_q;
  end

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave a latch behind.
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    free_ptr_d     = free_ptr_q;
    seg_start_d    = seg_start_q;
    iter_target_d  = iter_target_q;
    pass_idx_d     = pass_idx_q;
    pending_last_d = pending_last_q;
    last_inc       = 1'b0;
    last_dec       = 1'b0;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      last_inc = bus.wlast;
    end

    if (rd_acc) begin
      seg_start_d   = eff_start;
      iter_target_d = eff_target;
      if (!rlast) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        pass_idx_d = eff_pass;
        state_d    = S_PASS;
      end else if (eff_pass < eff_target) begin
        // Rewind for another pass; wr_ptr and free_ptr are untouched.
        rd_ptr_d   = eff_start;
        pass_idx_d = eff_pass + ITER_ONE;
        state_d    = S_PASS;
      end else begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        free_ptr_d = rd_ptr_q + PTR_ONE;
        pass_idx_d = '0;
        state_d    = S_IDLE;
        last_dec   = 1'b1;
      end
    end

    case ({last_inc, last_dec})
      2'b10:   pending_last_d = pending_last_q + PTR_ONE;
      2'b01:   pending_last_d = pending_last_q - PTR_ONE;
      default: pending_last_d = pending_last_q;
    endcase

    // A full buffer with no stored segment end can never drain: flag it until cleared.
    seg_overflow_d = seg_overflow_q | (wfull & (pending_last_q == '0));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      free_ptr_q     <= '0;
      seg_start_q    <= '0;
      pending_last_q <= '0;
      iter_target_q  <= '0;
      pass_idx_q     <= '0;
      seg_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      free_ptr_q     <= free_ptr_d;
      seg_start_q    <= seg_start_d;
      pending_last_q <= pending_last_d;
      iter_target_q  <= iter_target_d;
      pass_idx_q     <= pass_idx_d;
      seg_overflow_q <= seg_overflow_d;
    end
  end

  assign bus.wfull        = wfull;
  assign bus.count        = count;
  assign bus.rvalid       = rvalid;
  assign bus.rdata        = rd_word[DATA_W-1:0];
  assign bus.rlast        = rlast;
  assign bus.pass_idx     = pass_idx_q;
  assign bus.seg_overflow = seg_overflow_q;

endmodule

// File: tb/tb_cmd_replay_fifo.sv
// Directed bench for cmd_replay_fifo: plain FIFO, replay, full/concurrent, overflow, reset and
// replay_num stability scenarios with hand-computed expectations.
module tb_cmd_replay_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int IW    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  cmd_replay_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH), .ITER_W(IW)) bus ();

  cmd_replay_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ITER_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.winc       = 1'b0;
    bus.wdata      = '0;
    bus.wlast      = 1'b0;
    bus.rinc       = 1'b0;
    bus.replay_num = '0;
    flush          = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic l);
    bus.winc  = 1'b1;
    bus.wdata = d;
    bus.wlast = l;
    tick();
    bus.winc  = 1'b0;
    bus.wlast = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", bus.rvalid); end
    checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull: got %b want 0", bus.wfull); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.pass_idx !== IW'(0)) begin errors++; $display("FAIL reset_pass_idx: got %0d want 0", bus.pass_idx); end
    checks++; if (bus.seg_overflow !== 1'b0) begin errors++; $display("FAIL reset_seg_overflow: got %b want 0", bus.seg_overflow); end
  endtask

  task automatic test_plain_fifo();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 32'h0000_000A;
    exp_d[1] = 32'h0000_000B;
    exp_d[2] = 32'h0000_000C;
    bus.replay_num = '0;
    for (int i = 0; i < 3; i++) wr(exp_d[i], 1'b1);
    checks++; if (bus.count !== CW'(3)) begin errors++; $display("FAIL plain_count_full: got %0d want 3", bus.count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL plain_rvalid[%0d]: got %b want 1", i, bus.rvalid); end
      checks++; if (bus.rdata !== exp_d[i]) begin errors++; $display("FAIL plain_rdata[%0d]: got %h want %h", i, bus.rdata, exp_d[i]); end
      checks++; if (bus.rlast !== 1'b1) begin errors++; $display("FAIL plain_rlast[%0d]: got %b want 1", i, bus.rlast); end
      checks++; if (bus.pass_idx !== IW'(0)) begin errors++; $display("FAIL plain_pass_idx[%0d]: got %0d want 0", i, bus.pass_idx); end
      checks++; if (bus.count !== CW'(3 - i)) begin errors++; $display("FAIL plain_count[%0d]: got %0d want %0d", i, bus.count, 3 - i); end
      bus.rinc = 1'b1;
      tick();
    end
    bus.rinc = 1'b0;
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL plain_count_end: got %0d want 0", bus.count); end
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL plain_rvalid_end: got %b want 0", bus.rvalid); end
  endtask

  task automatic test_replay();
    logic [DW-1:0] p [3];
    p[0] = 32'h0000_0100;
    p[1] = 32'h0000_0101;
    p[2] = 32'h0000_0102;
    wr(p[0], 1'b0);
    wr(p[1], 1'b0);
    wr(p[2], 1'b1);
    bus.replay_num = IW'(2);
    for (int ps = 0; ps < 3; ps++) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (bus.rdata !== p[i]) begin errors++; $display("FAIL replay_rdata[%0d.%0d]: got %h want %h", ps, i, bus.rdata, p[i]); end
        checks++; if (bus.pass_idx !== IW'(ps)) begin errors++; $display("FAIL replay_pass_idx[%0d.%0d]: got %0d want %0d", ps, i, bus.pass_idx, ps); end
        checks++; if (bus.count !== CW'(3)) begin errors++; $display("FAIL replay_count[%0d.%0d]: got %0d want 3", ps, i, bus.count); end
        bus.rinc = 1'b1;
        tick();
      end
    end
    bus.rinc = 1'b0;
    bus.replay_num = '0;
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL replay_count_end: got %0d want 0", bus.count); end
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL replay_rvalid_end: got %b want 0", bus.rvalid); end
    checks++; if (bus.pass_idx !== IW'(0)) begin errors++; $display("FAIL replay_pass_idx_end: got %0d want 0", bus.pass_idx); end
  endtask

  task automatic test_single_entry();
    wr(32'h0000_0055, 1'b1);
    bus.replay_num = IW'(2);
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid[%0d]: got %b want 1", k, bus.rvalid); end
      checks++; if (bus.rdata !== 32'h0000_0055) begin errors++; $display("FAIL single_rdata[%0d]: got %h want 00000055", k, bus.rdata); end
      checks++; if (bus.pass_idx !== IW'(k)) begin errors++; $display("FAIL single_pass_idx[%0d]: got %0d want %0d", k, bus.pass_idx, k); end
      bus.rinc = 1'b1;
      tick();
    end
    bus.rinc = 1'b0;
    bus.replay_num = '0;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid_end: got %b want 0", bus.rvalid); end
  endtask

  task automatic test_replay_num_change();
    logic [DW-1:0] q [2];
    q[0] = 32'h0000_0200;
    q[1] = 32'h0000_0201;
    wr(q[0], 1'b0);
    wr(q[1], 1'b1);
    bus.replay_num = IW'(3);
    for (int n = 0; n < 8; n++) begin
      checks++; if (bus.rdata !== q[n % 2]) begin errors++; $display("FAIL rnum_rdata[%0d]: got %h want %h", n, bus.rdata, q[n % 2]); end
      checks++; if (bus.pass_idx !== IW'(n / 2)) begin errors++; $display("FAIL rnum_pass_idx[%0d]: got %0d want %0d", n, bus.pass_idx, n / 2); end
      bus.rinc = 1'b1;
      tick();
      bus.replay_num = '0;
    end
    bus.rinc = 1'b0;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rnum_rvalid_end: got %b want 0", bus.rvalid); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL rnum_count_end: got %0d want 0", bus.count); end
  endtask

  task automatic test_full_concurrent();
    for (int i = 0; i < 4; i++) wr(32'h0000_0300 + DW'(i), (i == 3));
    for (int i = 0; i < 12; i++) wr(32'h0000_0400 + DW'(i), 1'b1);
    checks++; if (bus.count !== CW'(16)) begin errors++; $display("FAIL full_count: got %0d want 16", bus.count); end
    checks++; if (bus.wfull !== 1'b1) begin errors++; $display("FAIL full_wfull: got %b want 1", bus.wfull); end
    wr(32'h0000_DEAD, 1'b1);
    checks++; if (bus.count !== CW'(16)) begin errors++; $display("FAIL full_drop_count: got %0d want 16", bus.count); end
    bus.replay_num = IW'(1);
    for (int ps = 0; ps < 2; ps++) begin
      for (int i = 0; i < 4; i++) begin
        if (ps == 1 && i == 3) begin
          checks++; if (bus.wfull !== 1'b1) begin errors++; $display("FAIL full_before_final: got %b want 1", bus.wfull); end
        end
        checks++; if (bus.rdata !== 32'h0000_0300 + DW'(i)) begin errors++; $display("FAIL full_seg_rdata[%0d.%0d]: got %h want %h", ps, i, bus.rdata, 32'h0000_0300 + DW'(i)); end
        checks++; if (bus.pass_idx !== IW'(ps)) begin errors++; $display("FAIL full_seg_pass[%0d.%0d]: got %0d want %0d", ps, i, bus.pass_idx, ps); end
        bus.rinc = 1'b1;
        tick();
      end
    end
    bus.rinc = 1'b0;
    bus.replay_num = '0;
    checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL full_after_final: got %b want 0", bus.wfull); end
    checks++; if (bus.count !== CW'(12)) begin errors++; $display("FAIL full_count_after: got %0d want 12", bus.count); end
    checks++; if (bus.rdata !== 32'h0000_0400) begin errors++; $display("FAIL full_next_rdata: got %h want 00000400", bus.rdata); end
    bus.rinc  = 1'b1;
    bus.winc  = 1'b1;
    bus.wdata = 32'h0000_0500;
    bus.wlast = 1'b1;
    tick();
    bus.rinc  = 1'b0;
    bus.winc  = 1'b0;
    bus.wlast = 1'b0;
    checks++; if (bus.count !== CW'(12)) begin errors++; $display("FAIL conc_count: got %0d want 12", bus.count); end
    for (int i = 1; i < 12; i++) begin
      checks++; if (bus.rdata !== 32'h0000_0400 + DW'(i)) begin errors++; $display("FAIL conc_rdata[%0d]: got %h want %h", i, bus.rdata, 32'h0000_0400 + DW'(i)); end
      bus.rinc = 1'b1;
      tick();
    end
    checks++; if (bus.rdata !== 32'h0000_0500) begin errors++; $display("FAIL conc_new_rdata: got %h want 00000500", bus.rdata); end
    tick();
    bus.rinc = 1'b0;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL conc_rvalid_end: got %b want 0", bus.rvalid); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL conc_count_end: got %0d want 0", bus.count); end
  endtask

  task automatic test_overflow();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 16; i++) wr(32'h0000_0600 + DW'(i), 1'b0);
    checks++; if (bus.wfull !== 1'b1) begin errors++; $display("FAIL ovf_wfull: got %b want 1", bus.wfull); end
    tick();
    checks++; if (bus.seg_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.seg_overflow); end
    tick();
    tick();
    tick();
    checks++; if (bus.seg_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.seg_overflow); end
    flush = 1'b1;
    bus.winc = 1'b1;
    bus.rinc = 1'b1;
    tick();
    flush = 1'b0;
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    checks++; if (bus.seg_overflow !== 1'b0) begin errors++; $display("FAIL ovf_flush_clear: got %b want 0", bus.seg_overflow); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL ovf_flush_count: got %0d want 0", bus.count); end
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL ovf_flush_rvalid: got %b want 0", bus.rvalid); end
  endtask

  task automatic test_reset_mid_pass();
    logic [DW-1:0] r [2];
    r[0] = 32'h0000_0700;
    r[1] = 32'h0000_0701;
    wr(r[0], 1'b0);
    wr(r[1], 1'b1);
    bus.replay_num = IW'(2);
    for (int n = 0; n < 3; n++) begin
      bus.rinc = 1'b1;
      tick();
    end
    bus.rinc = 1'b0;
    checks++; if (bus.pass_idx !== IW'(1)) begin errors++; $display("FAIL rst_mid_pass_idx: got %0d want 1", bus.pass_idx); end
    checks++; if (bus.rdata !== r[1]) begin errors++; $display("FAIL rst_mid_rdata: got %h want %h", bus.rdata, r[1]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid: got %b want 0", bus.rvalid); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", bus.count); end
    checks++; if (bus.pass_idx !== IW'(0)) begin errors++; $display("FAIL rst_mid_pass_after: got %0d want 0", bus.pass_idx); end
    bus.replay_num = '0;
    wr(32'h0000_0800, 1'b1);
    checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL rst_new_rvalid: got %b want 1", bus.rvalid); end
    checks++; if (bus.rdata !== 32'h0000_0800) begin errors++; $display("FAIL rst_new_rdata: got %h want 00000800", bus.rdata); end
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rst_new_rvalid_end: got %b want 0", bus.rvalid); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL rst_new_count_end: got %0d want 0", bus.count); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_plain_fifo();
    test_replay();
    test_single_entry();
    test_replay_num_change();
    test_full_concurrent();
    test_overflow();
    test_reset_mid_pass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
